// File: rtl/datapath_gen2_pkg.sv
// datapath_gen2_pkg: shared definitions for the datapath_gen2 core.
//   - opcode values OP_NOP..OP_HALT
//   - sequencer state encoding
//   - instruction field slicers; an instruction word is
//     {op[3:0], rd[RW-1:0], rs[RW-1:0], imm[DATA_W-1:0]}
//     and is passed in zero-extended to MAX_INSTR_W bits.
package datapath_gen2_pkg;

  // Widest instruction word the slicers accept.
  localparam int MAX_INSTR_W = 64;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_MOV   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_OUT   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JC    = 4'hC;
  localparam logic [3:0] OP_JMODE = 4'hD;
  localparam logic [3:0] OP_SHL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_LOADIR = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  function automatic logic [3:0] instr_op(input logic [MAX_INSTR_W-1:0] w,
                                          input int rw, input int dw);
    return 4'(w >> (2*rw + dw));
  endfunction

  function automatic logic [MAX_INSTR_W-1:0] instr_rd(input logic [MAX_INSTR_W-1:0] w,
                                                      input int rw, input int dw);
    logic [MAX_INSTR_W-1:0] mask;
    mask = (MAX_INSTR_W'(1) << rw) - MAX_INSTR_W'(1);
    return (w >> (rw + dw)) & mask;
  endfunction

  function automatic logic [MAX_INSTR_W-1:0] instr_rs(input logic [MAX_INSTR_W-1:0] w,
                                                      input int rw, input int dw);
    logic [MAX_INSTR_W-1:0] mask;
    mask = (MAX_INSTR_W'(1) << rw) - MAX_INSTR_W'(1);
    return (w >> dw) & mask;
  endfunction

  function automatic logic [MAX_INSTR_W-1:0] instr_imm(input logic [MAX_INSTR_W-1:0] w,
                                                       input int dw);
    logic [MAX_INSTR_W-1:0] mask;
    mask = (MAX_INSTR_W'(1) << dw) - MAX_INSTR_W'(1);
    return w & mask;
  endfunction

endpackage

// File: rtl/dp2_alu.sv
// dp2_alu: combinational ALU for the flag-setting ops (ADD/SUB/AND/OR/XOR/SHL).
//   op     in  4       opcode; other opcodes give result 0, carry 0
//   a      in  DATA_W  rd operand
//   b      in  DATA_W  rs operand
//   res    out DATA_W  result
//   carry  out 1       ADD carry-out, SUB borrow, SHL shifted-out bit, else 0
//   zero   out 1       res == 0
module dp2_alu
  import datapath_gen2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin res = sum[DATA_W-1:0]; carry = sum[DATA_W]; end
      OP_SUB: begin res = a - b;           carry = (a < b);     end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin res = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
      default: ;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/datapath_gen2.sv
// datapath_gen2: self-sequenced CPU datapath (register file, ALU, flags,
// branches). Each instruction takes FETCH -> LOADIR -> EXEC; HALT parks the
// core until reset. The ROM is external with one cycle of read latency.
//   Clk        in   1        rising-edge clock
//   Reset      in   1        asynchronous active-low reset
//   run        in   1        allows FETCH to advance
//   data_in    in   DATA_W   operand for IN
//   mode       in   ADDR_W   target for JMODE
//   instr_in   in   INSTR_W  ROM data for pc_addr, one cycle late
//   pc_addr    out  ADDR_W   ROM address (= PC)
//   Output     out  DATA_W   output register written by OUT
//   out_valid  out  1        pulse in the cycle after OUT executes
//   flag_z     out  1        zero flag
//   flag_c     out  1        carry / borrow flag
//   ir_op      out  4        opcode currently held in IR
//   halted     out  1        core is in HALT
module datapath_gen2
  import datapath_gen2_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NREG    = 4,
  localparam int RW      = $clog2(NREG),
  localparam int INSTR_W = 4 + 2*RW + DATA_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               run,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [ADDR_W-1:0]  mode,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_addr,
  output logic [DATA_W-1:0]  Output,
  output logic               out_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic [3:0]         ir_op,
  output logic               halted
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                z_q, z_d, c_q, c_d;

  logic [3:0]          op;
  logic [RW-1:0]       rd, rs;
  logic [DATA_W-1:0]   imm, rd_val, rs_val;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry, alu_zero;

  assign op  = instr_op(MAX_INSTR_W'(ir_q), RW, DATA_W);
  assign rd  = RW'(instr_rd(MAX_INSTR_W'(ir_q), RW, DATA_W));
  assign rs  = RW'(instr_rs(MAX_INSTR_W'(ir_q), RW, DATA_W));
  assign imm = DATA_W'(instr_imm(MAX_INSTR_W'(ir_q), DATA_W));

  // Operands come from the registered file, so rd==rs reads the old value.
  assign rd_val = regs_q[rd];
  assign rs_val = regs_q[rs];

  dp2_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .a     (rd_val),
    .b     (rs_val),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    z_d         = z_q;
    c_d         = c_q;
    case (state_q)
      S_FETCH: if (run) state_d = S_LOADIR;
      S_LOADIR: begin
        ir_d    = instr_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + ADDR_W'(1);
        case (op)
          OP_LDI: regs_d[rd] = imm;
          OP_MOV: regs_d[rd] = rs_val;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
            regs_d[rd] = alu_res;
            z_d        = alu_zero;
            c_d        = alu_carry;
          end
          OP_IN:    regs_d[rd] = data_in;
          OP_OUT: begin
            out_d       = rs_val;
            out_valid_d = 1'b1;
          end
          OP_JMP:   pc_d = imm[ADDR_W-1:0];
          OP_JZ:    if (z_q) pc_d = imm[ADDR_W-1:0];
          OP_JC:    if (c_q) pc_d = imm[ADDR_W-1:0];
          OP_JMODE: pc_d = mode;
          OP_HALT: begin
            // PC stays on the HALT instruction.
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  assign pc_addr   = pc_q;
  assign Output    = out_q;
  assign out_valid = out_valid_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign ir_op     = op;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_datapath_gen2.sv
// tb_datapath_gen2: directed programs plus random programs for datapath_gen2,
// checked against an instruction-level model of the ISA.
module tb_datapath_gen2;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int VMAX = 1 << DW;
  localparam int PCN  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  data_in = '0;
  logic [3:0]  mode = '0;
  logic [15:0] instr_in;
  logic [3:0]  pc_addr;
  logic [7:0]  out_w;
  logic        out_valid, flag_z, flag_c, halted;
  logic [3:0]  ir_op;

  datapath_gen2 #(.DATA_W(DW), .ADDR_W(AW), .NREG(4)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .run       (run),
    .data_in   (data_in),
    .mode      (mode),
    .instr_in  (instr_in),
    .pc_addr   (pc_addr),
    .Output    (out_w),
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .ir_op     (ir_op),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM, one cycle read latency.
  logic [15:0] rom [16];
  always @(posedge clk) instr_in <= rom[pc_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state.
  int m_pc, m_out, m_z, m_c, m_ov, m_halt;
  int m_regs [4];

  function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
    return 16'((op << 12) | (rd << 10) | (rs << 8) | (imm & 255));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset;
    m_pc = 0; m_out = 0; m_z = 0; m_c = 0; m_ov = 0; m_halt = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    run   = 1'b0;
    tick;
    tick;
    m_reset;
    rst_n = 1'b1;
  endtask

  // One instruction of the ISA, in plain arithmetic.
  task automatic m_exec(input logic [15:0] w);
    int op, rd, rs, imm, a, b, r, npc;
    op = int'(w[15:12]); rd = int'(w[11:10]); rs = int'(w[9:8]); imm = int'(w[7:0]);
    a = m_regs[rd]; b = m_regs[rs];
    npc = (m_pc + 1) % PCN;
    m_ov = 0;
    case (op)
      1:  m_regs[rd] = imm;
      2:  m_regs[rd] = b;
      3:  begin r = a + b; m_c = int'(r >= VMAX); r = r % VMAX; m_z = int'(r == 0); m_regs[rd] = r; end
      4:  begin m_c = int'(a < b); r = (a - b + VMAX) % VMAX; m_z = int'(r == 0); m_regs[rd] = r; end
      5:  begin r = a & b; m_c = 0; m_z = int'(r == 0); m_regs[rd] = r; end
      6:  begin r = a | b; m_c = 0; m_z = int'(r == 0); m_regs[rd] = r; end
      7:  begin r = a ^ b; m_c = 0; m_z = int'(r == 0); m_regs[rd] = r; end
      8:  m_regs[rd] = int'(data_in);
      9:  begin m_out = b; m_ov = 1; end
      10: npc = imm % PCN;
      11: if (m_z != 0) npc = imm % PCN;
      12: if (m_c != 0) npc = imm % PCN;
      13: npc = int'(mode);
      14: begin r = a * 2; m_c = int'(r >= VMAX); r = r % VMAX; m_z = int'(r == 0); m_regs[rd] = r; end
      15: m_halt = 1;
      default: ;
    endcase
    if (m_halt == 0) m_pc = npc;
  endtask

  // Run one instruction from FETCH (3 cycles) and compare against the model.
  task automatic step(input string tag);
    logic [15:0] w;
    w = rom[m_pc];
    run = 1'b1;
    tick; tick; tick;
    m_exec(w);
    chk({tag, ".ir_op"}, 32'(ir_op), 32'(w[15:12]));
    if (m_halt == 0) chk({tag, ".pc"}, 32'(pc_addr), 32'(m_pc));
    chk({tag, ".out"},    32'(out_w),     32'(m_out));
    chk({tag, ".z"},      32'(flag_z),    32'(m_z));
    chk({tag, ".c"},      32'(flag_c),    32'(m_c));
    chk({tag, ".ovalid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".halted"}, 32'(halted),    32'(m_halt));
  endtask

  initial begin
    logic [3:0] pc_hold;
    clear_rom;

    // Reset state.
    do_reset;
    chk("rst.pc", 32'(pc_addr), 32'h0);
    chk("rst.out", 32'(out_w), 32'h0);
    chk("rst.zc", 32'({flag_z, flag_c}), 32'h0);
    chk("rst.ovalid_halted", 32'({out_valid, halted}), 32'h0);
    chk("rst.ir_op", 32'(ir_op), 32'h0);

    // Reset in the middle of EXEC of LDI r1,0x55 must leave r1 at 0.
    rom[0] = ins(1, 1, 0, 8'h55);
    do_reset;
    run = 1'b1;
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("abort.pc", 32'(pc_addr), 32'h0);
    chk("abort.out", 32'(out_w), 32'h0);
    chk("abort.flags", 32'({flag_z, flag_c}), 32'h0);
    chk("abort.ir_op", 32'(ir_op), 32'h0);
    rom[0] = ins(9, 0, 1, 0);
    do_reset;
    step("abort_out");
    chk("abort.r1", 32'(out_w), 32'h0);

    // ADD with carry, then OUT: one out_valid pulse.
    clear_rom;
    rom[0] = ins(1, 0, 0, 8'hF0); rom[1] = ins(1, 1, 0, 8'h20);
    rom[2] = ins(3, 0, 1, 0);     rom[3] = ins(9, 0, 0, 0);
    do_reset;
    for (int i = 0; i < 4; i++) step("add");
    chk("add.out", 32'(out_w), 32'h10);
    chk("add.c", 32'(flag_c), 32'h1);
    chk("add.z", 32'(flag_z), 32'h0);
    run = 1'b0;
    tick;
    chk("add.pulse_end", 32'(out_valid), 32'h0);

    // SUB r2,r2 then JZ 9.
    clear_rom;
    rom[0] = ins(1, 2, 0, 8'h05); rom[1] = ins(4, 2, 2, 0); rom[2] = ins(11, 0, 0, 9);
    do_reset;
    step("subz"); step("subz");
    chk("subz.z", 32'(flag_z), 32'h1);
    chk("subz.c", 32'(flag_c), 32'h0);
    step("jz");
    chk("jz.pc", 32'(pc_addr), 32'h9);

    // 3 - 5 borrows, JC 7 taken, OUT r0 at 7 shows 0xFE.
    clear_rom;
    rom[0] = ins(1, 0, 0, 8'h03); rom[1] = ins(1, 1, 0, 8'h05);
    rom[2] = ins(4, 0, 1, 0);     rom[3] = ins(12, 0, 0, 7);
    rom[7] = ins(9, 0, 0, 0);
    do_reset;
    for (int i = 0; i < 3; i++) step("subc");
    chk("subc.c", 32'(flag_c), 32'h1);
    step("jc");
    chk("jc.pc", 32'(pc_addr), 32'h7);
    step("jc_out");
    chk("jc.r0", 32'(out_w), 32'hFE);

    // PC wraps after 16 NOPs.
    clear_rom;
    do_reset;
    for (int i = 0; i < 16; i++) step("wrap");
    chk("wrap.pc", 32'(pc_addr), 32'h0);

    // JMODE.
    rom[0] = ins(13, 0, 0, 0);
    mode = 4'hA;
    do_reset;
    step("jmode");
    chk("jmode.pc", 32'(pc_addr), 32'hA);

    // Stall in FETCH, then HALT.
    clear_rom;
    rom[0] = ins(1, 3, 0, 8'h77); rom[1] = ins(15, 0, 0, 0);
    do_reset;
    step("stall_ldi");
    run = 1'b0;
    repeat (5) tick;
    chk("stall.pc", 32'(pc_addr), 32'h1);
    chk("stall.ir_op", 32'(ir_op), 32'h1);
    step("halt");
    pc_hold = pc_addr;
    run = 1'b1;
    repeat (8) tick;
    chk("halt.pc_frozen", 32'(pc_addr), 32'(pc_hold));
    chk("halt.still", 32'(halted), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("halt.rst_halted", 32'(halted), 32'h0);
    chk("halt.rst_pc", 32'(pc_addr), 32'h0);

    // Random programs with random stalls.
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) begin
        int op;
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
        rom[i] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 255)));
      end
      mode = 4'($urandom);
      do_reset;
      for (int s = 0; s < 40; s++) begin
        if (m_halt != 0) break;
        data_in = 8'($urandom);
        if ($urandom_range(0, 4) == 0) begin
          run = 1'b0;
          repeat ($urandom_range(1, 3)) tick;
          chk("rnd.stall_pc", 32'(pc_addr), 32'(m_pc));
        end
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
